// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: instruction-memory
// port, decode-side control inputs, IF/ID outputs and interrupt signals.
interface if_fetch_stage_if;
  logic [31:0] inst_addr;
  logic [31:0] inst_in;
  logic        data_hazard_stall;
  logic        control_hazard_stall;
  logic        branch;
  logic [31:0] pc_branch_or_jump;
  logic        int_req;
  logic        eret;
  logic [31:0] IF_pc_4;
  logic [31:0] inst_out;
  logic        IF_valid;
  logic [31:0] epc;
  logic        int_ack;
  logic        in_handler;

  // Fetch stage view: drives address, IF/ID and interrupt status.
  modport master (
    output inst_addr, IF_pc_4, inst_out, IF_valid, epc, int_ack, in_handler,
    input  inst_in, data_hazard_stall, control_hazard_stall, branch,
           pc_branch_or_jump, int_req, eret
  );

  // Environment view: imem, decode and interrupt source.
  modport slave (
    input  inst_addr, IF_pc_4, inst_out, IF_valid, epc, int_ack, in_handler,
    output inst_in, data_hazard_stall, control_hazard_stall, branch,
           pc_branch_or_jump, int_req, eret
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register, EPC and a RUN/DEFER/HANDLER
// interrupt FSM. Redirects from decode keep the delay slot; an interrupt that
// coincides with a branch is deferred one edge so the delay slot stays whole.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0004,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_stage_if.master  bus
);
  typedef enum logic [1:0] {S_RUN, S_DEFER, S_HANDLER} state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_pc_4, w_pc_4_n;
  logic [31:0] r_inst, w_inst_n;
  logic        r_valid, w_valid_n;
  logic [31:0] r_epc, w_epc_n;
  logic        r_ack, w_ack_n;
  logic        w_stall;
  logic [31:0] w_seq_pc;

  assign w_stall  = bus.data_hazard_stall | bus.control_hazard_stall;
  assign w_seq_pc = r_pc + 32'd4;

  // Next PC / IF/ID / EPC / FSM, in edge priority order.
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_pc_4_n  = r_pc_4;
    w_inst_n  = r_inst;
    w_valid_n = r_valid;
    w_epc_n   = r_epc;
    w_ack_n   = 1'b0;
    if (w_stall) begin
      // everything holds; pending int_req/eret retried on next free edge
    end else if (bus.eret && r_state == S_HANDLER) begin
      w_pc_n    = r_epc;
      w_pc_4_n  = 32'd0;
      w_inst_n  = NOP_INST;
      w_valid_n = 1'b0;
      w_state_n = S_RUN;
    end else if (r_state == S_DEFER ||
                 (r_state == S_RUN && bus.int_req && !bus.branch)) begin
      // instruction currently in IF is squashed and refetched from epc
      w_epc_n   = r_pc;
      w_pc_n    = INT_VECTOR;
      w_pc_4_n  = 32'd0;
      w_inst_n  = NOP_INST;
      w_valid_n = 1'b0;
      w_ack_n   = 1'b1;
      w_state_n = S_HANDLER;
    end else begin
      // branch or sequential: the fetched instruction (maybe a delay slot) is kept
      w_pc_n    = bus.branch ? bus.pc_branch_or_jump : w_seq_pc;
      w_pc_4_n  = w_seq_pc;
      w_inst_n  = bus.inst_in;
      w_valid_n = 1'b1;
      if (bus.branch && bus.int_req && r_state == S_RUN)
        w_state_n = S_DEFER;
    end
  end

  // State registers, async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_pc_4  <= 32'd0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_epc   <= 32'd0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_pc_4  <= w_pc_4_n;
      r_inst  <= w_inst_n;
      r_valid <= w_valid_n;
      r_epc   <= w_epc_n;
      r_ack   <= w_ack_n;
    end
  end

  assign bus.inst_addr  = r_pc;
  assign bus.IF_pc_4    = r_pc_4;
  assign bus.inst_out   = r_inst;
  assign bus.IF_valid   = r_valid;
  assign bus.epc        = r_epc;
  assign bus.int_ack    = r_ack;
  assign bus.in_handler = (r_state == S_HANDLER);
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Instruction memory returns addr ^ A5A5_0000.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  if_fetch_stage_if bus();

  if_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign bus.inst_in = bus.inst_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc,
                        input logic [31:0] pc4, input logic [31:0] inst, input logic v);
    chk({tag, ".pc"},    bus.inst_addr, pc);
    chk({tag, ".pc4"},   bus.IF_pc_4,   pc4);
    chk({tag, ".inst"},  bus.inst_out,  inst);
    chk({tag, ".valid"}, {31'd0, bus.IF_valid}, {31'd0, v});
  endtask

  task automatic chk_int(input string tag, input logic [31:0] epc,
                         input logic ack, input logic hnd);
    chk({tag, ".epc"}, bus.epc, epc);
    chk({tag, ".ack"}, {31'd0, bus.int_ack}, {31'd0, ack});
    chk({tag, ".hnd"}, {31'd0, bus.in_handler}, {31'd0, hnd});
  endtask

  initial begin
    bus.data_hazard_stall    = 1'b0;
    bus.control_hazard_stall = 1'b0;
    bus.branch               = 1'b0;
    bus.pc_branch_or_jump    = 32'd0;
    bus.int_req              = 1'b0;
    bus.eret                 = 1'b0;
    step(); step();
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_int("rst", 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // sequential fetch
    step(); chk_if("seq1", 32'h4,  32'h4,  32'hA5A5_0000, 1'b1);
    step(); chk_if("seq2", 32'h8,  32'h8,  32'hA5A5_0004, 1'b1);
    step(); chk_if("seq3", 32'hC,  32'hC,  32'hA5A5_0008, 1'b1);
    step(); chk_if("seq4", 32'h10, 32'h10, 32'hA5A5_000C, 1'b1);

    // branch at 0x10 -> 0x40, delay slot kept
    bus.branch = 1'b1; bus.pc_branch_or_jump = 32'h40;
    step(); chk_if("br", 32'h40, 32'h14, 32'hA5A5_0010, 1'b1);
    bus.pc_branch_or_jump = 32'h20;
    step(); chk_if("br2", 32'h20, 32'h44, 32'hA5A5_0040, 1'b1);
    bus.branch = 1'b0;

    // load-use stall for two edges
    bus.data_hazard_stall = 1'b1;
    step(); chk_if("stl1", 32'h20, 32'h44, 32'hA5A5_0040, 1'b1);
    step(); chk_if("stl2", 32'h20, 32'h44, 32'hA5A5_0040, 1'b1);
    bus.data_hazard_stall = 1'b0;
    step(); chk_if("stl3", 32'h24, 32'h24, 32'hA5A5_0020, 1'b1);

    // interrupt entry at 0x30
    bus.branch = 1'b1; bus.pc_branch_or_jump = 32'h30;
    step(); bus.branch = 1'b0;
    bus.int_req = 1'b1;
    step(); chk_if("int", 32'h4, 32'h0, 32'h0, 1'b0); chk_int("int", 32'h30, 1'b1, 1'b1);
    bus.int_req = 1'b0;
    step(); chk(    "int.pc2", bus.inst_addr, 32'h8); chk_int("int2", 32'h30, 1'b0, 1'b1);
    bus.int_req = 1'b1;  // ignored while in handler
    step(); chk(    "nest.pc", bus.inst_addr, 32'hC); chk_int("nest", 32'h30, 1'b0, 1'b1);
    bus.int_req = 1'b0; bus.eret = 1'b1;
    step(); chk_if("eret", 32'h30, 32'h0, 32'h0, 1'b0); chk_int("eret", 32'h30, 1'b0, 1'b0);
    // eret in RUN is a plain instruction
    step(); chk_if("eretrun", 32'h34, 32'h34, 32'hA5A5_0030, 1'b1);
    bus.eret = 1'b0;

    // interrupt coinciding with branch -> DEFER
    bus.branch = 1'b1; bus.pc_branch_or_jump = 32'h50;
    step();
    bus.int_req = 1'b1; bus.pc_branch_or_jump = 32'h80;
    step(); chk_if("dfr1", 32'h80, 32'h54, 32'hA5A5_0050, 1'b1); chk_int("dfr1", 32'h30, 1'b0, 1'b0);
    bus.int_req = 1'b0; bus.branch = 1'b0;
    step(); chk_if("dfr2", 32'h4, 32'h0, 32'h0, 1'b0); chk_int("dfr2", 32'h80, 1'b1, 1'b1);
    bus.eret = 1'b1;
    step(); chk(    "dfr.ret", bus.inst_addr, 32'h80);
    bus.eret = 1'b0;

    // eret + int_req together in HANDLER: return, then re-enter next edge
    bus.int_req = 1'b1;
    step(); chk_int("b2b0", 32'h80, 1'b1, 1'b1);
    bus.eret = 1'b1;
    step(); chk(    "b2b1.pc", bus.inst_addr, 32'h80); chk_int("b2b1", 32'h80, 1'b0, 1'b0);
    bus.eret = 1'b0;
    step(); chk(    "b2b2.pc", bus.inst_addr, 32'h4); chk_int("b2b2", 32'h80, 1'b1, 1'b1);

    // stalled in HANDLER: no re-entry, eret waits for stall release
    bus.control_hazard_stall = 1'b1;
    step(); chk(    "hst1.pc", bus.inst_addr, 32'h4); chk_int("hst1", 32'h80, 1'b0, 1'b1);
    bus.int_req = 1'b0; bus.eret = 1'b1;
    step(); chk(    "hst2.pc", bus.inst_addr, 32'h4); chk_int("hst2", 32'h80, 1'b0, 1'b1);
    bus.control_hazard_stall = 1'b0;
    step(); chk(    "hst3.pc", bus.inst_addr, 32'h80); chk_int("hst3", 32'h80, 1'b0, 1'b0);
    bus.eret = 1'b0;

    // async reset mid-redirect while in handler
    bus.int_req = 1'b1;
    step(); bus.int_req = 1'b0;
    bus.branch = 1'b1; bus.pc_branch_or_jump = 32'h100;
    step(); chk(    "pre.pc", bus.inst_addr, 32'h100);
    #2 reset = 1'b1;
    #1;
    chk_if("arst", 32'h0, 32'h0, 32'h0, 1'b0); chk_int("arst", 32'h0, 1'b0, 1'b0);
    step(); reset = 1'b0;

    // PC wrap
    bus.pc_branch_or_jump = 32'hFFFF_FFFC;
    step(); chk(    "wrap0.pc", bus.inst_addr, 32'hFFFF_FFFC);
    bus.branch = 1'b0;
    step(); chk_if("wrap", 32'h0, 32'h0, 32'h5A5A_FFFC, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
